// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_pkg;

  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_TMO_W = 16;
  localparam logic [15:0] DEF_TMO_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [IDW-1:0]  ptr,
  input  logic [NREQ-1:0] valid,
  output logic [IDW-1:0]  winner,
  output logic [NREQ-1:0] grant_oh,
  output logic            any
);

  always_comb begin
    int unsigned idx;
    logic [IDW-1:0] sel;
    idx      = 0;
    sel      = '0;
    winner   = '0;
    grant_oh = '0;
    any      = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = IDW'(idx);
      if (!any && valid[sel]) begin
        any           = 1'b1;
        winner        = sel;
        grant_oh[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte requesters,
// with BUSY synchronization and a start-acknowledge timeout.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned      NREQ    = DEF_NREQ,
  parameter int unsigned      IDW     = $clog2(NREQ),
  parameter int unsigned      TMO_W   = DEF_TMO_W,
  parameter logic [TMO_W-1:0] TMO_MAX = TMO_W'(DEF_TMO_MAX)
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              EN,
  input  logic [NREQ-1:0]   REQ_VALID,
  input  logic [8*NREQ-1:0] REQ_DATA,
  output logic [NREQ-1:0]   REQ_READY,
  output logic              TX_START,
  output logic [7:0]        TX_DIN,
  input  logic              TX_BUSY,
  output logic [IDW-1:0]    GRANT_ID,
  output logic              ACTIVE,
  output logic              TMO_ERR
);

  state_t             state, state_nxt;
  logic               sync1, busy_s;
  logic [IDW-1:0]     ptr, ptr_nxt;
  logic [TMO_W-1:0]   cnt, cnt_nxt;
  logic [NREQ-1:0]    ready_nxt;
  logic               start_nxt, err_nxt;
  logic [7:0]         din_nxt, win_data;
  logic [IDW-1:0]     gid_nxt, win;
  logic [NREQ-1:0]    win_oh;
  logic               win_any;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .ptr      (ptr),
    .valid    (REQ_VALID),
    .winner   (win),
    .grant_oh (win_oh),
    .any      (win_any)
  );

  // TX_BUSY comes from the transmitter's tick domain
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      sync1  <= 1'b0;
      busy_s <= 1'b0;
    end else begin
      sync1  <= TX_BUSY;
      busy_s <= sync1;
    end
  end

  // AND-OR mux of the winning requester's byte
  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      win_data = win_data | (REQ_DATA[i*8 +: 8] & {8{win_oh[i]}});
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      REQ_READY <= '0;
      TX_START  <= 1'b0;
      TX_DIN    <= 8'h00;
      GRANT_ID  <= '0;
      ACTIVE    <= 1'b0;
      TMO_ERR   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      REQ_READY <= ready_nxt;
      TX_START  <= start_nxt;
      TX_DIN    <= din_nxt;
      GRANT_ID  <= gid_nxt;
      ACTIVE    <= (state_nxt != ST_IDLE);
      TMO_ERR   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    ready_nxt = '0;
    start_nxt = TX_START;
    din_nxt   = TX_DIN;
    gid_nxt   = GRANT_ID;
    err_nxt   = TMO_ERR;
    case (state)
      ST_IDLE: begin
        start_nxt = 1'b0;
        if (EN && win_any && !busy_s) begin
          ready_nxt = win_oh;
          din_nxt   = win_data;
          gid_nxt   = win;
          ptr_nxt   = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
          state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        start_nxt = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        cnt_nxt = cnt + TMO_W'(1);
        if (busy_s) begin
          start_nxt = 1'b0;
          state_nxt = ST_WAIT_DONE;
        end else if (cnt == TMO_MAX) begin
          // transmitter never acknowledged: drop the byte
          start_nxt = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy_s) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        start_nxt = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: directed requests, expected grants queued,
// a negedge monitor pops and checks each REQ_READY pulse and the launched byte.
module tb_uart_tx_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic            CLK = 1'b0;
  logic            RESETN = 1'b0;
  logic            EN = 1'b0;
  logic [NREQ-1:0] REQ_VALID = '0;
  logic [31:0]     REQ_DATA = '0;
  logic [NREQ-1:0] REQ_READY;
  logic            TX_START;
  logic [7:0]      TX_DIN;
  logic            TX_BUSY = 1'b0;
  logic [IDW-1:0]  GRANT_ID;
  logic            ACTIVE;
  logic            TMO_ERR;

  uart_tx_sched #(.NREQ(NREQ), .IDW(IDW), .TMO_W(16), .TMO_MAX(16'd16)) dut (
    .CLK(CLK), .RESETN(RESETN), .EN(EN),
    .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY),
    .TX_START(TX_START), .TX_DIN(TX_DIN), .TX_BUSY(TX_BUSY),
    .GRANT_ID(GRANT_ID), .ACTIVE(ACTIVE), .TMO_ERR(TMO_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { int idx; logic [7:0] data; } exp_t;
  exp_t expq[$];

  task automatic push(input int idx, input logic [7:0] data);
    exp_t e;
    e.idx = idx;
    e.data = data;
    expq.push_back(e);
  endtask

  // Monitor: grant pops, launch latency, TX_DIN hold, TX_START pulse length
  int grant_cnt = 0, grant_cyc = 0, rises = 0, falls = 0, start_len = 0, last_len = 0, fall_cyc = 0;
  logic [7:0] cur_data = '0;
  bit chk_next = 0;
  logic start_prev = 1'b0;

  initial forever begin
    @(negedge CLK);
    if (chk_next) begin
      check("start_latency", 32'(TX_START), 1);
      check("din_latch", 32'(TX_DIN), 32'(cur_data));
      chk_next = 0;
    end
    if (REQ_READY != '0) begin
      exp_t e;
      check("ready_onehot", 32'($onehot(REQ_READY)), 1);
      if (expq.size() == 0) check("unexpected_grant", 32'(REQ_READY), 0);
      else begin
        e = expq.pop_front();
        check("ready_id", 32'(REQ_READY), 32'(1) << e.idx);
        check("grant_id", 32'(GRANT_ID), e.idx);
        cur_data = e.data;
        chk_next = 1;
      end
      grant_cnt++;
      grant_cyc = cyc;
    end
    if (TX_START) begin
      if (!start_prev) begin
        rises++;
        start_len = 0;
      end
      start_len++;
    end else if (start_prev) begin
      falls++;
      last_len = start_len;
      fall_cyc = cyc;
      if (RESETN) check("din_hold", 32'(TX_DIN), 32'(cur_data));
    end
    start_prev = TX_START;
  end

  // Transmitter BUSY model: rises 4 cycles after START, high for frame_len cycles
  bit busy_auto = 1, busy_force = 0;
  int phase = 0, dly = 0, hold = 0, rise_cyc = 0, bfall_cyc = 0;
  int frame_len = 160;

  initial forever begin
    @(negedge CLK);
    if (!busy_auto) begin
      TX_BUSY = busy_force;
      phase = 0;
    end else begin
      case (phase)
        0: if (TX_START) begin dly = 3; phase = 1; end
        1: if (dly == 0) begin TX_BUSY = 1'b1; rise_cyc = cyc; hold = frame_len; phase = 2; end
           else dly--;
        2: begin
          hold--;
          if (hold == 0) begin TX_BUSY = 1'b0; bfall_cyc = cyc; phase = 3; end
        end
        default: if (!TX_START) phase = 0;
      endcase
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_grants(input int target, input int limit, input string name);
    int n = 0;
    while (grant_cnt < target && n < limit) begin step(); n++; end
    check(name, 32'(grant_cnt >= target), 1);
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (ACTIVE && n < limit) begin step(); n++; end
    check(name, 32'(ACTIVE), 0);
  endtask

  task automatic wait_falls(input int target, input int limit, input string name);
    int n = 0;
    while (falls < target && n < limit) begin step(); n++; end
    check(name, 32'(falls >= target), 1);
  endtask

  task automatic check_reset(input string p);
    check({p, "_ready"}, 32'(REQ_READY), 0);
    check({p, "_start"}, 32'(TX_START), 0);
    check({p, "_din"}, 32'(TX_DIN), 0);
    check({p, "_gid"}, 32'(GRANT_ID), 0);
    check({p, "_active"}, 32'(ACTIVE), 0);
    check({p, "_tmo"}, 32'(TMO_ERR), 0);
  endtask

  task automatic do_reset();
    RESETN = 1'b0;
    repeat (3) step();
    RESETN = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int g, f, r, en_cyc;
    // Reset state
    repeat (3) step();
    check_reset("rst");
    RESETN = 1'b1;
    step();

    // Single requester
    push(0, 8'hA5);
    REQ_DATA = 32'h000000A5;
    REQ_VALID = 4'b0001;
    EN = 1'b1;
    wait_grants(1, 10, "t1_grant");
    REQ_VALID = '0;
    wait_falls(1, 50, "t1_fall");
    check("t1_start_drop", 32'(fall_cyc - rise_cyc), 3);
    wait_idle(400, "t1_idle");
    check("t1_active_drop", 32'(cyc - bfall_cyc), 4);

    // All four valid from pointer 0
    do_reset();
    REQ_DATA = 32'h44332211;
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'h11);
    g = grant_cnt;
    REQ_VALID = 4'b1111;
    wait_grants(g + 5, 1200, "t2_grants");
    REQ_VALID = '0;
    wait_idle(400, "t2_idle");

    // Move pointer to 2, then only requesters 0 and 3 valid
    REQ_DATA = {8'h3C, 8'h00, 8'h55, 8'hC0};
    push(1, 8'h55);
    g = grant_cnt;
    REQ_VALID = 4'b0010;
    wait_grants(g + 1, 10, "t3_grant1");
    REQ_VALID = '0;
    wait_idle(400, "t3_idle1");
    push(3, 8'h3C); push(0, 8'hC0);
    REQ_VALID = 4'b1001;
    wait_grants(g + 2, 10, "t3_grant3");
    REQ_VALID = 4'b0001;
    wait_grants(g + 3, 400, "t3_grant0");
    REQ_VALID = '0;
    wait_idle(400, "t3_idle2");

    // Start-acknowledge timeout with BUSY held low
    busy_auto = 0;
    busy_force = 0;
    REQ_DATA = 32'h00006E00;
    push(1, 8'h6E);
    g = grant_cnt;
    f = falls;
    REQ_VALID = 4'b0010;
    wait_grants(g + 1, 10, "t4_grant");
    REQ_VALID = '0;
    wait_falls(f + 1, 40, "t4_fall");
    check("t4_start_len", 32'(last_len), 17);
    check("t4_tmo_set", 32'(TMO_ERR), 1);
    check("t4_back_idle", 32'(ACTIVE), 0);
    step();
    busy_auto = 1;
    REQ_DATA = 32'h005A0000;
    push(2, 8'h5A);
    REQ_VALID = 4'b0100;
    wait_grants(g + 2, 10, "t4_regrant");
    REQ_VALID = '0;
    wait_idle(400, "t4_idle");
    check("t4_tmo_sticky", 32'(TMO_ERR), 1);

    // EN dropped during WAIT_DONE with requester 1 pending
    REQ_DATA = 32'h77000000;
    push(3, 8'h77);
    g = grant_cnt;
    REQ_VALID = 4'b1000;
    wait_grants(g + 1, 10, "t5_grant");
    REQ_VALID = '0;
    for (int n = 0; n < 20 && !TX_BUSY; n++) step();
    repeat (5) step();
    check("t5_in_done", 32'({ACTIVE, TX_START}), 32'(2));
    EN = 1'b0;
    REQ_DATA = 32'h00009900;
    REQ_VALID = 4'b0010;
    g = grant_cnt;
    wait_idle(400, "t5_idle");
    repeat (20) step();
    check("t5_en_block", 32'(grant_cnt), 32'(g));
    push(1, 8'h99);
    EN = 1'b1;
    en_cyc = cyc;
    wait_grants(g + 1, 5, "t5_grant_en");
    check("t5_en_latency", 32'(grant_cyc - en_cyc), 1);
    REQ_VALID = '0;
    wait_idle(400, "t5_idle2");

    // Reset during WAIT_ACK
    busy_auto = 0;
    busy_force = 0;
    REQ_DATA = 32'h00E70000;
    push(2, 8'hE7);
    g = grant_cnt;
    REQ_VALID = 4'b0100;
    wait_grants(g + 1, 10, "t6_grant");
    REQ_VALID = '0;
    repeat (3) step();
    check("t6_in_ack", 32'(TX_START), 1);
    r = rises;
    RESETN = 1'b0;
    step();
    check_reset("t6");
    step();
    RESETN = 1'b1;
    repeat (40) step();
    check("t6_no_resend", 32'(rises), 32'(r));
    check("t6_tmo_clear", 32'(TMO_ERR), 0);

    // BUSY already high in IDLE blocks grants until it falls
    busy_force = 1;
    repeat (4) step();
    REQ_DATA = 32'h00000042;
    push(0, 8'h42);
    g = grant_cnt;
    REQ_VALID = 4'b0001;
    repeat (20) step();
    check("t7_busy_block", 32'(grant_cnt), 32'(g));
    busy_force = 0;
    wait_grants(g + 1, 10, "t7_grant");
    REQ_VALID = '0;
    busy_auto = 1;
    wait_idle(400, "t7_idle");

    check("queue_empty", 32'(expq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmitter between NREQ byte requesters (e.g. AHB write path, status/echo path, debug path).
- Accepts bytes over valid/ready, holds one byte, and drives the transmitter's START/DIN.
- Tracks transmitter BUSY through a synchronizer, because the transmitter sequences on its own divided tick clock.
- Sits between requesters and the transmitter; owns frame sequencing, fairness and stall timeout.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, grant index width, equal to clog2(NREQ).
- TMO_W, 16, width of the start-acknowledge timeout counter.
- TMO_MAX, 16'hFFFF, CLK cycles allowed from TX_START high to synchronized BUSY high.

Ports:
- CLK  in  1  system clock.
- RESETN  in  1  reset; synchronous, active-low.
- EN  in  1  scheduler enable; when low, no new grants are issued.
- REQ_VALID  in  NREQ  per-requester byte valid.
- REQ_DATA  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
- REQ_READY  out  NREQ  one-hot accept pulse.
- TX_START  out  1  start request to transmitter.
- TX_DIN  out  8  byte presented to transmitter.
- TX_BUSY  in  1  transmitter busy, asynchronous to CLK.
- GRANT_ID  out  IDW  index of the requester owning the current frame.
- ACTIVE  out  1  a frame is in progress (any state other than IDLE).
- TMO_ERR  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (RESETN low at a CLK edge):
  - REQ_READY=0, TX_START=0, TX_DIN=8'h00, GRANT_ID=0, ACTIVE=0, TMO_ERR=0.
  - Round-robin pointer=0, synchronizer flops=0, state=IDLE.
  - Reset applied mid-frame aborts the frame: TX_START drops on the next cycle and the held byte is discarded.
- TX_BUSY path: 2-flop synchronizer producing busy_s. All decisions use busy_s only.
- States:
  - IDLE: if EN=1 and any REQ_VALID bit is set, pick the winner (see Arbitration). Pulse REQ_READY[winner] for exactly 1 cycle, latch REQ_DATA slice into TX_DIN, set GRANT_ID=winner, go to LAUNCH. Handshake completes in that same cycle (REQ_VALID and REQ_READY both high).
  - LAUNCH: TX_START=1, timeout counter=0, go to WAIT_ACK.
  - WAIT_ACK: hold TX_START=1 and TX_DIN stable; increment counter every cycle.
    - busy_s=1: TX_START=0, go to WAIT_DONE.
    - counter==TMO_MAX first: TX_START=0, TMO_ERR=1, go to IDLE; byte dropped.
  - WAIT_DONE: wait for busy_s=0, then go to GAP.
  - GAP: one idle cycle so the transmitter re-enters its idle state before the next START; go to IDLE.
- Arbitration:
  - Round-robin starting at pointer p; the first valid requester in order p, p+1, ..., NREQ-1, 0, ..., p-1 wins.
  - After a grant, p = winner+1, wrapping from NREQ-1 to 0.
  - A single requester may be granted back-to-back when no one else is valid.
- Latency: REQ_READY pulse to TX_START high is 1 cycle. Minimum CLK cycles between consecutive REQ_READY pulses: 5 + 2 (synchronizer) + transmitter frame length.
- EN: EN=0 blocks only the IDLE grant. An in-flight frame always completes.
- Invariants:
  - TX_DIN is constant from the grant until the exit from WAIT_DONE.
  - REQ_VALID changes in non-IDLE states are ignored.
  - REQ_READY is at most one-hot.
- TX_BUSY already high in IDLE (e.g. transmitter still busy from before reset): no grant until busy_s=0.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants: ST_IDLE, ST_LAUNCH, ST_WAIT_ACK, ST_WAIT_DONE, ST_GAP.
  - Defaults for NREQ and TMO_MAX.
- Sub-module rr_arbiter (NREQ): combinational winner plus a one-hot valid flag, driven by the pointer.
- Synchronizer, counter and FSM stay in uart_tx_sched.

Test Plan:
- Single requester: REQ_VALID=4'b0001, REQ_DATA[7:0]=8'hA5, TX_BUSY model rises 4 cycles after START and stays high 160 cycles -> REQ_READY[0] 1-cycle pulse, TX_START high the next cycle, TX_DIN=8'hA5 held, TX_START low 1 cycle after busy_s rises, ACTIVE low after GAP.
- All four requesters valid continuously with bytes 11/22/33/44 -> grant order 0,1,2,3,0, REQ_READY never multi-hot, TX_DIN sequence 11,22,33,44,11.
- Pointer at 2 with only requesters 0 and 3 valid -> 3 granted first, then 0.
- TX_BUSY held low, TMO_MAX=16 -> TX_START high exactly 17 cycles, TMO_ERR=1 and sticky, state returns to IDLE, the next request is granted normally.
- EN dropped during WAIT_DONE with requester 1 pending -> current frame completes, no REQ_READY while EN=0, grant to 1 within 1 cycle of EN rising.
- RESETN low during WAIT_ACK -> all outputs reach reset values after that edge, the held byte is not re-sent after release, TMO_ERR=0.
